// File: rtl/lru_cache_wb.sv
// N-way set-associative write-back, write-allocate cache with true LRU replacement.
// Define LRU_CACHE_STATS_EN to add saturating hit_cnt/miss_cnt/wb_cnt outputs.
module lru_cache_wb #(
  parameter int WAYS       = 2,
  parameter int SET_BITS   = 5,
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 19,
  parameter int MEM_BYTES  = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [2:0]                           cpu_cmd,
  input  logic [ADDR_W-1:0]                    cpu_addr,
  input  logic [31:0]                          cpu_wdata,
  output logic [31:0]                          cpu_rdata,
  output logic                                 cpu_resp,
  output logic [1:0]                           mem_cmd,
  output logic [ADDR_W-$clog2(LINE_BYTES)-1:0] mem_addr,
  output logic [8*MEM_BYTES-1:0]               mem_wdata,
  input  logic [8*MEM_BYTES-1:0]               mem_rdata,
  input  logic                                 mem_resp
`ifdef LRU_CACHE_STATS_EN
  ,
  output logic [31:0]                          hit_cnt,
  output logic [31:0]                          miss_cnt,
  output logic [31:0]                          wb_cnt
`endif
);
  localparam int OFF_BITS = $clog2(LINE_BYTES);
  localparam int TAG_BITS = ADDR_W - SET_BITS - OFF_BITS;
  localparam int SETS     = 1 << SET_BITS;
  localparam int BEATS    = LINE_BYTES / MEM_BYTES;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Handshake: a request is taken only in IDLE with cpu_cmd != 0; the CPU holds
  // it until the one-cycle cpu_resp. mem_resp is a per-beat strobe in FILL and a
  // one-cycle write acknowledge in WB_WAIT; it is ignored everywhere else.
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, WB_WAIT, FILL_REQ, FILL, RESP} state_t;
  state_t state_q, state_d;

  logic [7:0]          data_q  [WAYS][SETS][LINE_BYTES];
  logic [TAG_BITS-1:0] tag_q   [WAYS][SETS];
  logic                valid_q [WAYS][SETS];
  logic                dirty_q [WAYS][SETS];
  logic [WAY_W-1:0]    age_q   [WAYS][SETS];

  logic [2:0]          req_cmd;
  logic [ADDR_W-1:0]   req_addr;
  logic [31:0]         req_wdata;
  logic [WAY_W-1:0]    way_q;
  logic [BEAT_W-1:0]   beat_q;

  logic [TAG_BITS-1:0] req_tag;
  logic [SET_BITS-1:0] req_set;
  logic [OFF_BITS-1:0] req_off;
  logic [ADDR_W-1:0]   acc_addr;
  logic [2:0]          nbytes;
  logic                req_wr, last_beat;
  logic                hit, inv_found, victim_dirty;
  logic [WAY_W-1:0]    hit_way, inv_way, lru_way, victim;

  assign req_tag   = req_addr[ADDR_W-1 -: TAG_BITS];
  assign req_set   = req_addr[OFF_BITS +: SET_BITS];
  assign req_off   = req_addr[OFF_BITS-1:0];
  assign req_wr    = req_cmd[2];
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    acc_addr = cpu_addr;
    if (cpu_cmd[1:0] == 2'd2)      acc_addr[0]   = 1'b0;
    else if (cpu_cmd[1:0] == 2'd3) acc_addr[1:0] = 2'b00;
  end

  always_comb begin
    case (req_cmd[1:0])
      2'd2:    nbytes = 3'd2;
      2'd3:    nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
  end

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_set] && (tag_q[w][req_set] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][req_set] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[w][req_set] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim       = inv_found ? inv_way : lru_way;
    victim_dirty = valid_q[victim][req_set] && dirty_q[victim][req_set];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cpu_cmd != 3'd0) state_d = LOOKUP;
      LOOKUP:   state_d = hit ? RESP : (victim_dirty ? WB : FILL_REQ);
      WB:       if (last_beat) state_d = WB_WAIT;
      WB_WAIT:  if (mem_resp) state_d = FILL_REQ;
      FILL_REQ: state_d = FILL;
      FILL:     if (mem_resp && last_beat) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_resp  = (state_q == RESP);
    cpu_rdata = '0;
    mem_cmd   = 2'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == RESP && !req_wr) begin
      for (int b = 0; b < 4; b++)
        if (3'(b) < nbytes) cpu_rdata[8*b +: 8] = data_q[way_q][req_set][req_off + OFF_BITS'(b)];
    end
    if (state_q == WB) begin
      mem_cmd  = 2'd3;
      mem_addr = {tag_q[way_q][req_set], req_set};
      for (int i = 0; i < MEM_BYTES; i++)
        mem_wdata[8*i +: 8] = data_q[way_q][req_set][OFF_BITS'(int'(beat_q) * MEM_BYTES + i)];
    end
    if (state_q == FILL_REQ) mem_cmd = 2'd2;
    if (state_q == FILL_REQ || state_q == FILL) mem_addr = {req_tag, req_set};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_cmd   <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      way_q     <= '0;
      beat_q    <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          age_q[w][s]   <= WAY_W'(w);
        end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (cpu_cmd != 3'd0) begin
          req_cmd   <= cpu_cmd;
          req_addr  <= acc_addr;
          req_wdata <= cpu_wdata;
        end
        LOOKUP: begin
          way_q  <= hit ? hit_way : victim;
          beat_q <= '0;
        end
        WB: beat_q <= beat_q + 1'b1;
        FILL_REQ: begin
          valid_q[way_q][req_set] <= 1'b0;
          beat_q                  <= '0;
        end
        FILL: if (mem_resp) begin
          beat_q <= beat_q + 1'b1;
          if (last_beat) begin
            valid_q[way_q][req_set] <= 1'b1;
            dirty_q[way_q][req_set] <= 1'b0;
          end
        end
        RESP: begin
          if (req_wr) dirty_q[way_q][req_set] <= 1'b1;
          // Touched way becomes youngest; ways younger than its old age move up one.
          if (WAYS > 1) begin
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_W'(w) == way_q) age_q[w][req_set] <= '0;
              else if (age_q[w][req_set] < age_q[way_q][req_set])
                age_q[w][req_set] <= age_q[w][req_set] + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (state_q == FILL_REQ) tag_q[way_q][req_set] <= req_tag;
    if (state_q == FILL && mem_resp) begin
      for (int i = 0; i < MEM_BYTES; i++)
        data_q[way_q][req_set][OFF_BITS'(int'(beat_q) * MEM_BYTES + i)] <= mem_rdata[8*i +: 8];
    end
    if (state_q == RESP && req_wr) begin
      for (int b = 0; b < 4; b++)
        if (3'(b) < nbytes) data_q[way_q][req_set][req_off + OFF_BITS'(b)] <= req_wdata[8*b +: 8];
    end
  end

`ifdef LRU_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        if (victim_dirty && wb_cnt != '1) wb_cnt <= wb_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lru_cache_wb.sv
// Bench for lru_cache_wb: directed table, hand sequences for eviction/reset, and
// random accesses checked against a flat-memory + recency-list cache model.
module tb_lru_cache_wb;
  localparam int ADDR_W = 19;
  localparam int LINE_BYTES = 16;
  localparam int BEATS = 8;
  localparam int SETS = 32;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  cpu_cmd = '0;
  logic [18:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_resp;
  logic [1:0]  mem_cmd;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;
`ifdef LRU_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  lru_cache_wb dut (
    .clk(clk), .reset(reset), .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_resp(cpu_resp),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
`ifdef LRU_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  task automatic hang(input string name);
    mismatched++;
    $display("FAIL %s: no DUT event within the cycle budget", name);
    finish_run();
  endtask

  // ---------------- memory side: backing store and responder ----------------
  logic [7:0]  mem_w[int];
  logic [15:0] wb_data[$];
  logic [15:0] log_q[$];
  int mmode = 0, fill_beat = 0, wait_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  logic [14:0] fill_line, wb_line;

  function automatic logic [7:0] back_byte(input int a);
    return mem_w.exists(a) ? mem_w[a] : a[7:0];
  endfunction

  always @(negedge clk) begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    if (reset) mmode = 0;
    else begin
      case (mmode)
        0: begin
          if (mem_cmd == 2'd2) begin
            rd_cnt++;
            log_q.push_back({1'b0, mem_addr});
            fill_line = mem_addr;
            fill_beat = 0;
            mmode = 1;
          end else if (mem_cmd == 2'd3) begin
            log_q.push_back({1'b1, mem_addr});
            wb_line = mem_addr;
            wb_data.delete();
            wb_data.push_back(mem_wdata);
            mmode = 2;
          end
        end
        1: if ($urandom_range(0, 3) != 0) begin
          mem_resp = 1'b1;
          for (int k = 0; k < 2; k++)
            mem_rdata[8*k +: 8] = back_byte(int'(fill_line) * LINE_BYTES + fill_beat * 2 + k);
          fill_beat++;
          if (fill_beat == BEATS) mmode = 0;
        end
        2: if (mem_cmd == 2'd3) begin
          wb_data.push_back(mem_wdata);
          if (wb_data.size() == BEATS) begin
            mmode = 3;
            wait_cnt = $urandom_range(0, 3);
          end
        end
        3: if (wait_cnt == 0) begin
          logic [15:0] bt;
          mem_resp = 1'b1;
          for (int b = 0; b < BEATS; b++) begin
            bt = wb_data[b];
            mem_w[int'(wb_line) * LINE_BYTES + 2*b]     = bt[7:0];
            mem_w[int'(wb_line) * LINE_BYTES + 2*b + 1] = bt[15:8];
          end
          wr_cnt++;
          mmode = 0;
        end else wait_cnt--;
        default: mmode = 0;
      endcase
    end
  end

  // ---------------- reference model: CPU-visible bytes + recency lists ----------------
  logic [7:0] ref_mem[int];
  int lru_m[SETS][$];
  bit dirty_m[int];

  function automatic logic [7:0] ref_byte(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : a[7:0];
  endfunction

  // A reset discards dirty lines, so the visible memory falls back to the backing store.
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) lru_m[s].delete();
    dirty_m.delete();
    ref_mem.delete();
    foreach (mem_w[k]) ref_mem[k] = mem_w[k];
  endtask

  task automatic model_access(input int line, input bit wr, output bit hit, output bit wb);
    int s, found, v;
    s = line % SETS;
    found = -1;
    hit = 1'b0;
    wb = 1'b0;
    for (int i = 0; i < lru_m[s].size(); i++) if (lru_m[s][i] == line) found = i;
    if (found >= 0) begin
      hit = 1'b1;
      lru_m[s].delete(found);
    end else begin
      if (lru_m[s].size() == WAYS) begin
        v = lru_m[s].pop_back();
        wb = dirty_m.exists(v) && dirty_m[v];
      end
      dirty_m[line] = 1'b0;
    end
    lru_m[s].push_front(line);
    if (wr) dirty_m[line] = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_cmd = '0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic access(input logic [2:0] cmd, input int addr, input logic [31:0] wd,
                        output logic [31:0] rd, output bit hit_seen);
    int sz, a, lat, rd0, wr0;
    bit mhit, mwb;
    logic [31:0] exp;
    sz = (cmd[1:0] == 2'd3) ? 4 : (cmd[1:0] == 2'd2) ? 2 : 1;
    a = addr & ~(sz - 1);
    exp = '0;
    if (!cmd[2]) for (int k = 0; k < sz; k++) exp[8*k +: 8] = ref_byte(a + k);
    exp_q.push_back(exp);
    model_access(a / LINE_BYTES, cmd[2], mhit, mwb);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    cpu_cmd = cmd;
    cpu_addr = 19'(addr);
    cpu_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_resp && lat < 400);
    if (!cpu_resp) hang("cpu_resp");
    rd = cpu_rdata;
    cpu_cmd = '0;
    hit_seen = (lat == 2);
    check("rdata", rd, exp_q.pop_front());
    check("hit", {31'b0, hit_seen}, {31'b0, mhit});
    check("read_line_cnt", 32'(rd_cnt - rd0), {31'b0, !mhit});
    check("write_line_cnt", 32'(wr_cnt - wr0), {31'b0, mwb});
    if (cmd[2]) for (int k = 0; k < sz; k++) ref_mem[a + k] = wd[8*k +: 8];
  endtask

  typedef struct {
    logic [2:0]  cmd;
    int          addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_hit;
    int          exp_rd;
  } vec_t;
  vec_t vecs[8];

  initial begin : watchdog
    #900000;
    hang("watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit h;
    int n;
    vecs[0] = '{3'd3, 'h040, 32'h0,        32'h43424140, 1'b0, 1};
    vecs[1] = '{3'd3, 'h040, 32'h0,        32'h43424140, 1'b1, 1};
    vecs[2] = '{3'd6, 'h102, 32'h0000BEEF, 32'h0,        1'b0, 2};
    vecs[3] = '{3'd2, 'h102, 32'h0,        32'h0000BEEF, 1'b1, 2};
    vecs[4] = '{3'd1, 'h103, 32'h0,        32'h000000BE, 1'b1, 2};
    vecs[5] = '{3'd1, 'h102, 32'h0,        32'h000000EF, 1'b1, 2};
    vecs[6] = '{3'd3, 'h101, 32'h0,        32'hBEEF0100, 1'b1, 2};
    vecs[7] = '{3'd2, 'h107, 32'h0,        32'h00000706, 1'b1, 2};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("reset_cpu_resp", {31'b0, cpu_resp}, 32'h0);
    check("reset_cpu_rdata", cpu_rdata, 32'h0);
    check("reset_mem_cmd", {30'b0, mem_cmd}, 32'h0);
    check("reset_mem_addr", {17'b0, mem_addr}, 32'h0);
    check("reset_mem_wdata", {16'b0, mem_wdata}, 32'h0);

    // Directed table: first fill, hit latency, write merge and aligned reads.
    for (int i = 0; i < 8; i++) begin
      access(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, rd, h);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_hit", i), {31'b0, h}, {31'b0, vecs[i].exp_hit});
      check($sformatf("vec%0d_reads", i), 32'(rd_cnt), 32'(vecs[i].exp_rd));
    end
    check("first_read_line_addr", {16'b0, log_q[0]}, 32'h0004);

    // Dirty eviction: write-back of line 0 precedes the fill of line 0x040.
    do_reset();
    log_q.delete();
    access(3'd7, 'h000, 32'hCAFEF00D, rd, h);
    access(3'd1, 'h200, 32'h0, rd, h);
    access(3'd1, 'h400, 32'h0, rd, h);
    check("evict_log_len", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      check("evict_log0", {16'b0, log_q[0]}, 32'h0000);
      check("evict_log1", {16'b0, log_q[1]}, 32'h0020);
      check("evict_log2", {16'b0, log_q[2]}, 32'h8000);
      check("evict_log3", {16'b0, log_q[3]}, 32'h0040);
    end
    check("wb_beats", 32'(wb_data.size()), 32'(BEATS));
    for (int b = 0; b < BEATS; b++) begin
      logic [15:0] e;
      e = (b == 0) ? 16'hF00D : (b == 1) ? 16'hCAFE : {8'(2*b + 1), 8'(2*b)};
      if (b < wb_data.size()) check($sformatf("wb_beat%0d", b), {16'b0, wb_data[b]}, {16'b0, e});
    end
`ifdef LRU_CACHE_STATS_EN
    check("stat_hit", hit_cnt, 32'd0);
    check("stat_miss", miss_cnt, 32'd3);
    check("stat_wb", wb_cnt, 32'd1);
`endif
    access(3'd3, 'h000, 32'h0, rd, h);
    check("refetch_written_line", rd, 32'hCAFEF00D);

    // LRU order: re-touching line 0 makes 0x200 the victim.
    do_reset();
    n = wr_cnt;
    access(3'd1, 'h000, 32'h0, rd, h);
    access(3'd1, 'h200, 32'h0, rd, h);
    access(3'd1, 'h000, 32'h0, rd, h);
    access(3'd1, 'h400, 32'h0, rd, h);
    access(3'd1, 'h000, 32'h0, rd, h);
    check("lru_keeps_line0", {31'b0, h}, 32'h1);
    access(3'd1, 'h200, 32'h0, rd, h);
    check("lru_evicted_0x200", {31'b0, h}, 32'h0);
    check("lru_no_write_line", 32'(wr_cnt - n), 32'h0);

    // Reset in the middle of a fill aborts the read without a response.
    do_reset();
    @(negedge clk);
    cpu_cmd = 3'd3;
    cpu_addr = 19'h00040;
    n = 0;
    while (!(mmode == 1 && fill_beat >= 3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) hang("fill_beat3");
    reset = 1'b1;
    cpu_cmd = '0;
    @(negedge clk);
    check("abort_mem_cmd", {30'b0, mem_cmd}, 32'h0);
    check("abort_cpu_resp", {31'b0, cpu_resp}, 32'h0);
    check("abort_mem_addr", {17'b0, mem_addr}, 32'h0);
    reset = 1'b0;
    model_reset();
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_resp) n++;
    end
    check("abort_no_resp", 32'(n), 32'h0);
    n = rd_cnt;
    access(3'd3, 'h040, 32'h0, rd, h);
    check("abort_reissue_rdata", rd, 32'h43424140);
    check("abort_reissue_miss", {31'b0, h}, 32'h0);

    // Random traffic over a few conflicting lines in two sets.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      logic [2:0] cmd;
      int a;
      case ($urandom_range(0, 5))
        0: cmd = 3'd1;
        1: cmd = 3'd2;
        2: cmd = 3'd3;
        3: cmd = 3'd5;
        4: cmd = 3'd6;
        default: cmd = 3'd7;
      endcase
      a = (int'($urandom_range(0, 3)) << 9) | (int'($urandom_range(0, 1)) << 4) |
          int'($urandom_range(0, 15));
      access(cmd, a, $urandom, rd, h);
    end

    finish_run();
  end
endmodule
